instruction_fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection and the IF/ID pipeline register.
- Drives the instruction-memory address and captures the returned instruction into IF/ID.
- Consumes the load-use stall from the hazard detection unit, and branch/jump redirects resolved in ID.
- Detects the HALT instruction and freezes fetch; a debug-unit enable gates all state updates.

---
 rtl/instruction_fetch_stage.sv | 126 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage
// Description : IF stage of a 5-stage MIPS pipeline. It holds the PC register,
//               selects the next PC, drives the instruction-memory address and
//               captures the fetched instruction into the IF/ID register.
//               It honours the load-use stall, applies ID-resolved jump/branch
//               redirects with a flush, freezes fetch on a HALT instruction,
//               and holds all state while the debug enable is low.
// Ports       :
//   i_clk           clock, all state updates on the rising edge
//   i_reset         synchronous active-high reset
//   i_enable        debug-unit enable; low holds all state
//   i_stall         load-use stall from the hazard detection unit
//   i_branch_taken  ID-resolved taken branch
//   i_branch_addr   branch target
//   i_jump          ID-resolved jump (J/JAL/JR/JALR)
//   i_jump_addr     jump target
//   i_instr         instruction read combinationally from imem at o_pc
//   o_pc            current PC, imem address
//   o_if_id_instr   IF/ID instruction
//   o_if_id_pc4     IF/ID PC+4
//   o_if_id_valid   1 = real instruction in IF/ID, 0 = bubble
//   o_halted        fetch halted
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
    parameter int                   NB_PC       = 32,
    parameter int                   NB_INSTR    = 32,
    parameter logic [NB_PC-1:0]     RESET_PC    = '0,
    parameter logic [NB_INSTR-1:0]  HALT_OPCODE = 32'hFFFF_FFFF,
    parameter logic [NB_INSTR-1:0]  NOP_INSTR   = 32'h0000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [NB_PC-1:0]     i_branch_addr,
    input  logic                 i_jump,
    input  logic [NB_PC-1:0]     i_jump_addr,
    input  logic [NB_INSTR-1:0]  i_instr,
    output logic [NB_PC-1:0]     o_pc,
    output logic [NB_INSTR-1:0]  o_if_id_instr,
    output logic [NB_PC-1:0]     o_if_id_pc4,
    output logic                 o_if_id_valid,
    output logic                 o_halted
);

    localparam logic [0:0]        c_ST_RUN    = 1'b0;
    localparam logic [0:0]        c_ST_HALTED = 1'b1;
    localparam logic [NB_PC-1:0]  c_PC_STEP   = NB_PC'(4);

    logic [0:0]           r_state;
    logic [NB_PC-1:0]     r_pc;
    logic [NB_INSTR-1:0]  r_if_id_instr;
    logic [NB_PC-1:0]     r_if_id_pc4;
    logic                 r_if_id_valid;

    logic [NB_PC-1:0]     w_pc_plus4;
    logic [NB_PC-1:0]     w_jump_target;
    logic [NB_PC-1:0]     w_branch_target;
    logic                 w_is_halt;

    // Wraps modulo 2^NB_PC by construction.
    assign w_pc_plus4      = r_pc + c_PC_STEP;
    // Targets are always word aligned regardless of what ID hands us.
    assign w_jump_target   = {i_jump_addr[NB_PC-1:2], 2'b00};
    assign w_branch_target = {i_branch_addr[NB_PC-1:2], 2'b00};
    assign w_is_halt       = (i_instr == HALT_OPCODE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= c_ST_RUN;
            r_pc          <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                c_ST_RUN: begin
                    // While stalled the ID instruction is not yet valid, so
                    // any redirect it presents is ignored too.
                    if (!i_stall) begin
                        if (i_jump) begin
                            r_pc          <= w_jump_target;
                            r_if_id_instr <= NOP_INSTR;
                            r_if_id_valid <= 1'b0;
                        end else if (i_branch_taken) begin
                            r_pc          <= w_branch_target;
                            r_if_id_instr <= NOP_INSTR;
                            r_if_id_valid <= 1'b0;
                        end else if (w_is_halt) begin
                            // Pass the HALT down once; PC freezes on it.
                            r_if_id_instr <= i_instr;
                            r_if_id_pc4   <= w_pc_plus4;
                            r_if_id_valid <= 1'b1;
                            r_state       <= c_ST_HALTED;
                        end else begin
                            r_if_id_instr <= i_instr;
                            r_if_id_pc4   <= w_pc_plus4;
                            r_if_id_valid <= 1'b1;
                            r_pc          <= w_pc_plus4;
                        end
                    end
                end
                default: begin
                    // Halted: feed bubbles; a stall keeps the HALT in IF/ID
                    // until ID can accept it.
                    if (!i_stall) begin
                        r_if_id_instr <= NOP_INSTR;
                        r_if_id_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_if_id_instr = r_if_id_instr;
    assign o_if_id_pc4   = r_if_id_pc4;
    assign o_if_id_valid = r_if_id_valid;
    assign o_halted      = (r_state == c_ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Self-checking bench for instruction_fetch_stage. Directed
//               scenarios followed by randomized cycles, each checked against
//               a behavioural model of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

    localparam logic [31:0] c_HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] c_NOP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        stall;
    logic        br;
    logic [31:0] baddr;
    logic        jmp;
    logic [31:0] jaddr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_stall        (stall),
        .i_branch_taken (br),
        .i_branch_addr  (baddr),
        .i_jump         (jmp),
        .i_jump_addr    (jaddr),
        .i_instr        (instr),
        .o_pc           (pc),
        .o_if_id_instr  (if_id_instr),
        .o_if_id_pc4    (if_id_pc4),
        .o_if_id_valid  (if_id_valid),
        .o_halted       (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next-state of the fetch stage described directly from its rules.
    task automatic model_step(input logic r, e, s, b, input logic [31:0] ba,
                              input logic j, input logic [31:0] ja, input logic [31:0] ins);
        if (r) begin
            m_pc = 32'h0; m_instr = c_NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
        end else if (!e || s) begin
            // frozen
        end else if (m_halted) begin
            m_instr = c_NOP; m_valid = 1'b0;
        end else if (j) begin
            m_pc = ja & ~32'h3; m_instr = c_NOP; m_valid = 1'b0;
        end else if (b) begin
            m_pc = ba & ~32'h3; m_instr = c_NOP; m_valid = 1'b0;
        end else begin
            m_instr = ins; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            if (ins == c_HALT) m_halted = 1'b1;
            else               m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic r, e, s, b, input logic [31:0] ba,
                        input logic j, input logic [31:0] ja, input logic [31:0] ins);
        @(negedge clk);
        rst = r; en = e; stall = s; br = b; baddr = ba; jmp = j; jaddr = ja; instr = ins;
        model_step(r, e, s, b, ba, j, ja, ins);
        @(posedge clk);
        #1;
        chk("pc",     pc,               m_pc);
        chk("instr",  if_id_instr,      m_instr);
        chk("pc4",    if_id_pc4,        m_pc4);
        chk("valid",  32'(if_id_valid), 32'(m_valid));
        chk("halted", 32'(halted),      32'(m_halted));
    endtask

    // Plain enabled fetch of one instruction
    task automatic fetch(input logic [31:0] ins);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ins);
    endtask

    initial begin
        logic [31:0] f_pc, f_instr, f_pc4;
        logic        f_valid, f_halted;

        rst = 1'b1; en = 1'b0; stall = 1'b0; br = 1'b0; baddr = '0;
        jmp = 1'b0; jaddr = '0; instr = '0;
        m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_halted = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h1234);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);

        // Sequential fetch
        fetch(32'h2001_0001);
        chk("seq_pc4", pc, 32'h4);
        fetch(32'h2002_0002);
        chk("seq_pc8", pc, 32'h8);
        chk("seq_if_instr", if_id_instr, 32'h2002_0002);

        // Stall with a pending branch: both ignored
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h2003_0003);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h2003_0003);
        chk("stall_pc", pc, 32'h8);
        chk("stall_pc4", if_id_pc4, 32'h8);
        fetch(32'h2003_0003);
        chk("resume_pc", pc, 32'hC);

        // Jump beats branch, target aligned
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h103, 32'h2004_0004);
        chk("jmp_pc", pc, 32'h100);
        chk("jmp_valid", 32'(if_id_valid), 32'h0);

        // HALT at 0x10
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h0);
        fetch(c_HALT);
        chk("halt_instr", if_id_instr, c_HALT);
        chk("halt_flag", 32'(halted), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, c_HALT);
        chk("halt_pc", pc, 32'h10);
        chk("halt_drain", 32'(if_id_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("halt_rst", 32'(halted), 32'h0);

        // HALT held in IF/ID while stalled in HALTED
        fetch(c_HALT);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, c_HALT);
        chk("halt_stall_hold", if_id_instr, c_HALT);
        fetch(c_HALT);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Redirect squashes a fetched HALT
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, c_HALT);
        chk("squash_pc", pc, 32'h20);
        chk("squash_halt", 32'(halted), 32'h0);

        // Debug enable low freezes everything
        fetch(32'h1111_0000);
        f_pc = pc; f_instr = if_id_instr; f_pc4 = if_id_pc4;
        f_valid = if_id_valid; f_halted = halted;
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'(i % 2), 1'(i < 3), 32'h400, 1'(i == 4), 32'h500, c_HALT);
        chk("en_pc", pc, f_pc);
        chk("en_instr", if_id_instr, f_instr);
        chk("en_pc4", if_id_pc4, f_pc4);
        chk("en_valid", 32'(if_id_valid), 32'(f_valid));
        chk("en_halted", 32'(halted), 32'(f_halted));

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        fetch(32'h2222_0000);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);

        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rins;
            rins = ($urandom_range(0, 11) == 0) ? c_HALT : $urandom;
            step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0), $urandom,
                 1'($urandom_range(0, 7) == 0), $urandom, rins);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
